// File: rtl/mult_pool_alloc.sv
// Round-robin allocator for the shared multiplier pool: owns the occupancy bitmap,
// streams free indices to one requester at a time and accepts releases.
// Optional feature macro: MULT_POOL_PARTIAL_EN (honor req_partial_ok when the pool is short).
module mult_pool_alloc #(
    parameter int NMULT = 64,
    parameter int MW    = 6,
    parameter int NREQ  = 4,
    parameter int RW    = 2,
    parameter int CW    = 7
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*CW-1:0]  req_count,
    input  logic [NREQ-1:0]     req_partial_ok,
    output logic                grant_valid,
    input  logic                grant_ready,
    output logic [MW-1:0]       grant_idx,
    output logic [RW-1:0]       grant_id,
    output logic                grant_last,
    output logic [NREQ-1:0]     req_done,
    output logic [CW-1:0]       done_count,
    input  logic                rel_valid,
    input  logic [MW-1:0]       rel_idx,
    output logic [NMULT-1:0]    occ,
    output logic [MW:0]         free_cnt,
    output logic                busy,
    output logic                rel_err
);

    typedef enum logic [2:0] {IDLE, CHECK, PICK, OFFER, DONE} state_t;

    state_t             state_q;
    logic [RW-1:0]      rr_ptr_q;
    logic [RW-1:0]      sel_q;
    logic [CW-1:0]      target_q;
    logic [CW-1:0]      issued_q;
    logic [MW-1:0]      cand_q;
    logic [NMULT-1:0]   occ_q;
    logic [NMULT-1:0]   occ_d;
    logic               rel_err_q;
    logic               grant_valid_q;
    logic [RW-1:0]      grant_id_q;
    logic               grant_last_q;
    logic [NREQ-1:0]    req_done_q;
    logic [CW-1:0]      done_count_q;
    logic               busy_q;
    logic               skip_q;

    logic [MW:0]        used_cnt;
    logic [MW-1:0]      free_idx;
    logic [NREQ-1:0]    req_avail;
    logic               scan_found;
    logic [RW-1:0]      scan_sel;
    logic [CW-1:0]      cur_cnt;
    logic               cnt_fits;
    logic               partial_ok;
    logic               rel_bad;
    logic [RW-1:0]      sel_next;

    assign grant_valid = grant_valid_q;
    assign grant_idx   = cand_q;
    assign grant_id    = grant_id_q;
    assign grant_last  = grant_last_q;
    assign req_done    = req_done_q;
    assign done_count  = done_count_q;
    assign occ         = occ_q;
    assign busy        = busy_q;
    assign rel_err     = rel_err_q;

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < NMULT; i++) begin
            used_cnt = used_cnt + {{MW{1'b0}}, occ_q[i]};
        end
    end

    assign free_cnt = (MW+1)'(NMULT) - used_cnt;

    always_comb begin
        free_idx = '0;
        for (int i = NMULT - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_idx = MW'(i);
            end
        end
    end

    // The requester just served is hidden for one IDLE cycle so a late
    // req_valid drop cannot cause a duplicate service.
    always_comb begin
        req_avail = req_valid;
        if (skip_q) begin
            req_avail[sel_q] = 1'b0;
        end
        scan_found = 1'b0;
        scan_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!scan_found && req_avail[RW'((32'(rr_ptr_q) + i) % NREQ)]) begin
                scan_found = 1'b1;
                scan_sel   = RW'((32'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    assign cur_cnt  = req_count[sel_q*CW +: CW];
    assign cnt_fits = 32'(free_cnt) >= 32'(cur_cnt);
    assign sel_next = RW'((32'(sel_q) + 1) % NREQ);

`ifdef MULT_POOL_PARTIAL_EN
    assign partial_ok = req_partial_ok[sel_q];
`else
    logic unused_partial;
    assign unused_partial = ^req_partial_ok;
    assign partial_ok     = 1'b0;
`endif

    // A release is checked against the current bitmap, so releasing the index
    // being granted in the same cycle counts as an error and the grant wins.
    always_comb begin
        occ_d   = occ_q;
        rel_bad = 1'b0;
        if (rel_valid) begin
            if (occ_q[rel_idx]) begin
                occ_d[rel_idx] = 1'b0;
            end else begin
                rel_bad = 1'b1;
            end
        end
        if (state_q == OFFER && grant_valid_q && grant_ready) begin
            occ_d[cand_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            sel_q         <= '0;
            target_q      <= '0;
            issued_q      <= '0;
            cand_q        <= '0;
            occ_q         <= '0;
            rel_err_q     <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_last_q  <= 1'b0;
            req_done_q    <= '0;
            done_count_q  <= '0;
            busy_q        <= 1'b0;
            skip_q        <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            req_done_q <= '0;
            if (rel_bad) begin
                rel_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    skip_q <= 1'b0;
                    if (scan_found) begin
                        sel_q   <= scan_sel;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cur_cnt == '0) begin
                        target_q          <= '0;
                        done_count_q      <= '0;
                        req_done_q[sel_q] <= 1'b1;
                        state_q           <= DONE;
                    end else if (cnt_fits) begin
                        target_q <= cur_cnt;
                        state_q  <= PICK;
                    end else if (partial_ok && free_cnt != '0) begin
                        target_q <= CW'(free_cnt);
                        state_q  <= PICK;
                    end else begin
                        rr_ptr_q <= sel_next;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                PICK: begin
                    cand_q        <= free_idx;
                    grant_valid_q <= 1'b1;
                    grant_id_q    <= sel_q;
                    grant_last_q  <= (issued_q == target_q - CW'(1));
                    state_q       <= OFFER;
                end
                OFFER: begin
                    if (grant_ready) begin
                        grant_valid_q <= 1'b0;
                        issued_q      <= issued_q + CW'(1);
                        if (grant_last_q) begin
                            req_done_q[sel_q] <= 1'b1;
                            done_count_q      <= target_q;
                            state_q           <= DONE;
                        end else begin
                            state_q <= PICK;
                        end
                    end
                end
                DONE: begin
                    issued_q <= '0;
                    rr_ptr_q <= sel_next;
                    skip_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_pool_alloc.sv
// Directed self-checking bench for mult_pool_alloc; expectations are hand-derived
// and tracked with a small occupancy model.
module tb_mult_pool_alloc;

    localparam int NMULT = 64;
    localparam int MW    = 6;
    localparam int NREQ  = 4;
    localparam int RW    = 2;
    localparam int CW    = 7;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*CW-1:0]  req_count;
    logic [NREQ-1:0]     req_partial_ok;
    logic                grant_valid;
    logic                grant_ready;
    logic [MW-1:0]       grant_idx;
    logic [RW-1:0]       grant_id;
    logic                grant_last;
    logic [NREQ-1:0]     req_done;
    logic [CW-1:0]       done_count;
    logic                rel_valid;
    logic [MW-1:0]       rel_idx;
    logic [NMULT-1:0]    occ;
    logic [MW:0]         free_cnt;
    logic                busy;
    logic                rel_err;

    int          compareCount = 0;
    int          mismatchCount = 0;
    logic [63:0] expOcc;
    bit          expErr;
    int          expIdx[64];

    mult_pool_alloc #(.NMULT(NMULT), .MW(MW), .NREQ(NREQ), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_count(req_count), .req_partial_ok(req_partial_ok),
        .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_idx(grant_idx),
        .grant_id(grant_id), .grant_last(grant_last),
        .req_done(req_done), .done_count(done_count),
        .rel_valid(rel_valid), .rel_idx(rel_idx),
        .occ(occ), .free_cnt(free_cnt), .busy(busy), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input int cnt);
        req_valid[id] = 1'b1;
        req_count[id*CW +: CW] = CW'(cnt);
    endtask

    task automatic releaseIdx(input int idx);
        rel_valid = 1'b1;
        rel_idx   = MW'(idx);
        if (!expOcc[idx]) expErr = 1'b1;
        expOcc[idx] = 1'b0;
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic checkPool(input string tag);
        repeat (2) @(negedge clk);
        checkOutput({tag, " occ"}, occ, expOcc);
        checkOutput({tag, " free_cnt"}, free_cnt, 64'(NMULT - $countones(expOcc)));
        checkOutput({tag, " rel_err"}, rel_err, expErr);
        checkOutput({tag, " busy"}, busy, 0);
    endtask

    // t0 < 0 disables latency checks (request already pending for unknown cycles).
    task automatic serveRequest(input string tag, input int id, input int cnt, input int nExp, input int t0);
        int  k;
        bit  doneSeen;
        k = 0;
        doneSeen = 1'b0;
        applyStimulus(id, cnt);
        for (int c = 1; c <= 400 && !doneSeen; c++) begin
            @(negedge clk);
            if (grant_valid) begin
                if (k < nExp) begin
                    checkOutput({tag, " idx"}, grant_idx, expIdx[k]);
                    checkOutput({tag, " id"}, grant_id, id);
                    checkOutput({tag, " last"}, grant_last, k == nExp - 1);
                    if (t0 >= 0) checkOutput({tag, " grant cycle"}, c, t0 + 3 + 2*k);
                    expOcc[expIdx[k]] = 1'b1;
                end else begin
                    checkOutput({tag, " extra grant"}, 1, 0);
                end
                k++;
            end
            if (req_done != '0) begin
                checkOutput({tag, " req_done"}, req_done, 64'(1) << id);
                checkOutput({tag, " done_count"}, done_count, nExp);
                checkOutput({tag, " grants"}, k, nExp);
                if (t0 >= 0) checkOutput({tag, " done cycle"}, c, t0 + 2 + 2*nExp);
                req_valid[id] = 1'b0;
                doneSeen = 1'b1;
            end
        end
        if (!doneSeen) checkOutput({tag, " timeout"}, 0, 1);
    endtask

    initial begin
        bit seen;
        bit seenD;
        rstn = 1'b0;
        req_valid = '0;
        req_count = '0;
        req_partial_ok = '0;
        grant_ready = 1'b1;
        rel_valid = 1'b0;
        rel_idx = '0;
        expOcc = '0;
        expErr = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        checkOutput("reset grant_valid", grant_valid, 0);
        checkOutput("reset grant_idx", grant_idx, 0);
        checkOutput("reset grant_id", grant_id, 0);
        checkOutput("reset grant_last", grant_last, 0);
        checkOutput("reset req_done", req_done, 0);
        checkOutput("reset done_count", done_count, 0);
        checkOutput("reset occ", occ, 0);
        checkOutput("reset free_cnt", free_cnt, 64);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rel_err", rel_err, 0);

        expIdx[0] = 0; expIdx[1] = 1; expIdx[2] = 2;
        serveRequest("full", 0, 3, 3, 0);
        checkPool("full");

        // rr_ptr now points at 1, so req2 beats req0.
        applyStimulus(0, 1);
        expIdx[0] = 3;
        serveRequest("rr first", 2, 1, 1, 0);
        expIdx[0] = 4;
        serveRequest("rr second", 0, 1, 1, 1);
        checkPool("rr");

        releaseIdx(4);
        checkPool("release ok");

        applyStimulus(1, 2);
        grant_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = grant_valid;
        end
        checkOutput("bp offer seen", seen, 1);
        checkOutput("bp idx", grant_idx, 4);
        checkOutput("bp id", grant_id, 1);
        checkOutput("bp last", grant_last, 0);
        for (int s = 1; s <= 5; s++) begin
            if (s == 2) begin
                rel_valid = 1'b1;
                rel_idx = 6'd1;
                expOcc[1] = 1'b0;
            end else begin
                rel_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput("bp stall valid", grant_valid, 1);
            checkOutput("bp stall idx", grant_idx, 4);
            checkOutput("bp stall last", grant_last, 0);
        end
        grant_ready = 1'b1;
        expOcc[4] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            seen = grant_valid;
        end
        checkOutput("bp second seen", seen, 1);
        checkOutput("bp second idx", grant_idx, 1);
        checkOutput("bp second last", grant_last, 1);
        expOcc[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            seen = (req_done != '0);
        end
        checkOutput("bp req_done", req_done, 4'b0010);
        checkOutput("bp done_count", done_count, 2);
        req_valid[1] = 1'b0;
        checkPool("bp");

        releaseIdx(5);
        checkPool("rel_err free");

        expIdx[0] = 5; expIdx[1] = 6;
        serveRequest("fill56", 3, 2, 2, 0);
        checkPool("fill56");
        releaseIdx(5);
        expIdx[0] = 5;
        serveRequest("reuse5", 0, 1, 1, 0);
        checkPool("reuse5");

        serveRequest("zero", 2, 0, 0, 0);
        checkPool("zero");

        for (int i = 0; i < 55; i++) expIdx[i] = 7 + i;
        serveRequest("fill61", 3, 55, 55, 0);
        checkPool("fill61");

        req_partial_ok[1] = 1'b1;
`ifdef MULT_POOL_PARTIAL_EN
        expIdx[0] = 62; expIdx[1] = 63;
        serveRequest("partial", 1, 4, 2, 0);
        checkPool("partial");
`else
        applyStimulus(1, 4);
        seen = 1'b0;
        seenD = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (grant_valid) seen = 1'b1;
            if (req_done != '0) seenD = 1'b1;
        end
        checkOutput("nopartial grant", seen, 0);
        checkOutput("nopartial done", seenD, 0);
        checkOutput("nopartial occ", occ, expOcc);
        releaseIdx(0);
        releaseIdx(1);
        expIdx[0] = 0; expIdx[1] = 1; expIdx[2] = 62; expIdx[3] = 63;
        serveRequest("nopartial serve", 1, 4, 4, -1);
        checkPool("nopartial");
`endif
        req_partial_ok[1] = 1'b0;

        releaseIdx(10);
        applyStimulus(2, 1);
        grant_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = grant_valid;
        end
        checkOutput("rst offer seen", seen, 1);
        checkOutput("rst offer idx", grant_idx, 10);
        rstn = 1'b0;
        req_valid = '0;
        expOcc = '0;
        expErr = 1'b0;
        #1;
        checkOutput("rst async occ", occ, 0);
        checkOutput("rst async grant_valid", grant_valid, 0);
        checkOutput("rst async busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        grant_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst after occ", occ, 0);
        checkOutput("rst after free_cnt", free_cnt, 64);
        checkOutput("rst after grant_valid", grant_valid, 0);
        checkOutput("rst after rel_err", rel_err, 0);
        checkOutput("rst after busy", busy, 0);
        expIdx[0] = 0;
        serveRequest("post reset", 0, 1, 1, 0);
        checkPool("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mult_pool_alloc.md
# mult_pool_alloc

Central allocator for the shared multiplier pool used by the convolution controllers. It arbitrates round-robin among up to NREQ requesters, each asking for a number of multipliers. For the selected requester it issues free multiplier indices one at a time over a valid/ready stream and marks them occupied. It also accepts release of indices when a requester finishes, and is the single owner of the pool occupancy bitmap.

## Interface
- NMULT, 64, number of multipliers in the pool
- MW, 6, multiplier index width, equal to clog2(NMULT)
- NREQ, 4, number of requesters
- RW, 2, requester id width, equal to clog2(NREQ)
- CW, 7, request count width; a count may range from 0 to NMULT

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request; held until that requester's req_done
- req_count  in  NREQ*CW  packed counts; requester r occupies bits [r*CW +: CW]
- req_partial_ok  in  NREQ  requester accepts fewer multipliers than requested
- grant_valid  out  1  grant_idx is offered
- grant_ready  in  1  consumer accepts the offered grant
- grant_idx  out  MW  offered multiplier index
- grant_id  out  RW  requester being served
- grant_last  out  1  the offered grant is the final one for this request
- req_done  out  NREQ  one-cycle pulse marking the end of service
- done_count  out  CW  number of multipliers granted; valid with req_done
- rel_valid  in  1  release request
- rel_idx  in  MW  index to release
- occ  out  NMULT  occupancy bitmap; 1 = occupied
- free_cnt  out  MW+1  NMULT minus popcount(occ), combinational from occ
- busy  out  1  high whenever the state is not IDLE
- rel_err  out  1  sticky; set when a free index is released

## Operation
- Register state: state, rr_ptr, sel, target, issued, cand, occ, rel_err, and all outputs.
- IDLE
  - Scan req_valid starting at rr_ptr and wrapping; the first set bit is stored in sel.
  - If any request is found, go to CHECK.
- CHECK, with cnt = req_count[sel]:
  - If cnt == 0: target = 0, go to DONE.
  - Else if free_cnt >= cnt: target = cnt, go to PICK.
  - Else if partial is allowed (see Configuration) and free_cnt > 0: target = free_cnt, go to PICK.
  - Otherwise skip: rr_ptr = sel+1 mod NREQ, go to IDLE. The request stays pending.
- PICK: cand = lowest index with occ == 0, then go to OFFER.
- OFFER
  - Drive grant_valid=1, grant_idx=cand, grant_id=sel, grant_last=(issued == target-1).
  - On handshake: set occ[cand] and increment issued.
  - After the handshake, go to DONE if grant_last was high, else PICK.
- DONE
  - Pulse req_done[sel] and drive done_count=target.
  - Clear issued, set rr_ptr = sel+1 mod NREQ, go to IDLE.
- Release
  - On rel_valid, occ[rel_idx] is cleared at the clock edge, in any state.
  - If occ[rel_idx] was already 0, occ is unchanged and rel_err is set.
  - A release and a grant handshake in the same cycle are both applied.
- Only this block sets occ bits, so free_cnt never drops below target - issued during service.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - grant_valid=0, grant_idx=0, grant_id=0, grant_last=0.
  - req_done=0, done_count=0, occ=0, rel_err=0, busy=0.
  - free_cnt=NMULT.
- Reset mid-operation abandons the request and frees the whole pool.
- Request present in IDLE at cycle t: CHECK at t+1, PICK at t+2, first grant_valid at t+3.
- With grant_ready tied high, grant k (0-based) is offered at t+3+2k.
- DONE is the cycle after the last handshake, so req_done fires at t+2+2*target.
- For a zero count, req_done fires at t+2 with no grant_valid.
- While grant_valid=1 and grant_ready=0, grant_idx, grant_id and grant_last are held stable. Releases during the stall do not change them.
- A requester must deassert req_valid on the edge following its req_done. IDLE does not re-serve that requester in the following cycle.

## Configuration
- Macro MULT_POOL_PARTIAL_EN.
- Defined: req_partial_ok is honored as described in CHECK.
- Undefined: req_partial_ok is ignored, and a request is only served when free_cnt >= count; otherwise it is skipped.

## Test plan
- Full grant, ready=1: after reset, req0 count=3 → grant_idx 0,1,2 at t+3, t+5, t+7; grant_last with idx 2; req_done[0] at t+8 with done_count=3; free_cnt=61.
- Round-robin: serve req0, then assert req0 and req2 together → req2 is served first (grant_id=2), then req0.
- Insufficient pool: indices 0..61 occupied, req1 count=4 with req_partial_ok=1:
  - Macro defined: grants 62 and 63, done_count=2.
  - Macro undefined: no grant_valid, and req1 stays pending until a release brings free_cnt to 4.
- Backpressure: grant_ready=0 for 5 cycles with grant_idx=4 offered, and index 1 released mid-stall → grant_idx stays 4; the next PICK selects 1.
- Release errors: release idx 5 when free → rel_err=1 and occ unchanged; release occupied idx 5 → the next request's first grant is idx 5.
- Edge cases: count=0 → req_done at t+2, done_count=0, no grants; rstn asserted during OFFER → occ=0, grant_valid=0, state IDLE on the next cycle.
